// File: rtl/parallel_out_arbiter.sv
// Round-robin write arbiter for the shared parallel output register, with a hold window after each write.
// Optional build macro PARALLEL_OUT_PRIO0_EN gives requester 0 fixed priority over the round robin.
module parallel_out_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         dataOut,
    output logic                      wren,
    output logic                      busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              take;

    logic              win_valid;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  ptr_after;
    logic              ptr_adv;
    logic [N_REQ-1:0]  win_onehot;
    logic [DATA_W-1:0] win_data;

    // Scan downward from the farthest offset so the closest set bit to ptr is written last and wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (req[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
`ifdef PARALLEL_OUT_PRIO0_EN
        if (req[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
        end
`endif
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_onehot[i] = (win_idx == PTR_W'(i));
        end
        win_data  = req_data[win_idx*DATA_W +: DATA_W];
        ptr_after = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
`ifdef PARALLEL_OUT_PRIO0_EN
        ptr_adv   = (win_idx != '0);
`else
        ptr_adv   = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    take       = 1'b1;
                    state_next = HOLD;
                    cnt_next   = CNT_LOAD;
                    if (ptr_adv) begin
                        ptr_next = ptr_after;
                    end
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == HOLD);
    end

    // Grant and write strobe are registered so they line up with the new dataOut in the first HOLD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            wren    <= 1'b0;
            dataOut <= '0;
        end else begin
            gnt  <= take ? win_onehot : '0;
            wren <= take;
            if (take) begin
                dataOut <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_parallel_out_arbiter.sv
// Self-checking bench for parallel_out_arbiter: directed steps plus random traffic against a cycle-level model.
module tb_parallel_out_arbiter;

    localparam int N_REQ       = 4;
    localparam int DATA_W      = 8;
    localparam int HOLD_CYCLES = 4;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       dataOut;
    logic                    wren;
    logic                    busy;
    logic                    clk_run;

    int n_pass;
    int n_fail;

    int                m_ptr;
    int                m_hold;
    logic [N_REQ-1:0]  m_gnt;
    logic              m_wren;
    logic [DATA_W-1:0] m_data;

    parallel_out_arbiter #(
        .N_REQ(N_REQ),
        .DATA_W(DATA_W),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .dataOut(dataOut),
        .wren(wren),
        .busy(busy)
    );

    // Gated clock so reset can be exercised with no edges at all.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    function automatic void modelReset();
        m_ptr  = 0;
        m_hold = 0;
        m_gnt  = '0;
        m_wren = 1'b0;
        m_data = '0;
    endfunction

    // One rising edge: m_hold counts the remaining HOLD cycles, zero means idle.
    function automatic void modelStep(input logic [N_REQ-1:0] r, input logic [N_REQ*DATA_W-1:0] d);
        int w;
        w = -1;
        if (m_hold > 0) begin
            m_hold = m_hold - 1;
            m_gnt  = '0;
            m_wren = 1'b0;
        end else if (r == '0) begin
            m_gnt  = '0;
            m_wren = 1'b0;
        end else begin
`ifdef PARALLEL_OUT_PRIO0_EN
            if (r[0]) w = 0;
`endif
            for (int k = 0; k < N_REQ; k++) begin
                if (w < 0 && r[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
            end
            m_data    = d[w*DATA_W +: DATA_W];
            m_gnt     = '0;
            m_gnt[w]  = 1'b1;
            m_wren    = 1'b1;
            m_hold    = HOLD_CYCLES;
`ifdef PARALLEL_OUT_PRIO0_EN
            if (w != 0) m_ptr = (w + 1) % N_REQ;
`else
            m_ptr = (w + 1) % N_REQ;
`endif
        end
    endfunction

    task automatic checkOutput(input string tag);
        assert (gnt === m_gnt) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s gnt: observed %b expected %b", tag, gnt, m_gnt);
        end
        assert (wren === m_wren) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s wren: observed %b expected %b", tag, wren, m_wren);
        end
        assert (dataOut === m_data) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s dataOut: observed %h expected %h", tag, dataOut, m_data);
        end
        assert (busy === (m_hold > 0)) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, (m_hold > 0));
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ*DATA_W-1:0] d,
                                 input string tag);
        @(negedge clk);
        checkOutput(tag);
        req      = r;
        req_data = d;
        modelStep(r, d);
    endtask

    // Stops the clock low, pulses rst and checks the outputs clear without any edge.
    task automatic doAsyncReset(input string tag);
        @(negedge clk);
        checkOutput(tag);
        clk_run = 1'b0;
        #2 rst = 1'b1;
        modelReset();
        #1 checkOutput({tag, "_in_reset"});
        assert (dataOut === 8'h00) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s_cleared dataOut: observed %h expected 00", tag, dataOut);
        end
        #10 checkOutput({tag, "_clk_stopped"});
        #1 rst = 1'b0;
        clk_run = 1'b1;
        modelStep(req, req_data);
    endtask

    initial begin
        logic [N_REQ-1:0]        r;
        logic [N_REQ*DATA_W-1:0] d;
        n_pass   = 0;
        n_fail   = 0;
        clk_run  = 1'b1;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        modelReset();
        #3 checkOutput("reset");
        @(negedge clk);
        rst = 1'b0;
        modelStep(req, req_data);

        applyStimulus(4'b0001, 32'h0000_00A5, "single_write");
        repeat (6) applyStimulus(4'b0000, 32'h0, "single_hold");

        repeat (21) applyStimulus(4'b1111, 32'h4433_2211, "round_robin");

        for (int i = 0; i < 40 && !(m_ptr == 3 && m_hold == 0); i++) begin
            applyStimulus(4'b1111, 32'h4433_2211, "rr_to_ptr3");
        end
        repeat (12) applyStimulus(4'b1001, 32'hD0C0_B0A0, "wrap_skip");

        repeat (6) applyStimulus(4'b0000, 32'h0, "drain");
        applyStimulus(4'b0010, 32'h0000_5A00, "pre_reset_write");
        applyStimulus(4'b0010, 32'h0000_5A00, "hold_first");
        doAsyncReset("mid_hold_reset");
        repeat (8) applyStimulus(4'b0010, 32'h0000_5A00, "after_reset");

        for (int i = 0; i < 30; i++) begin
            r = 4'b1110 | ((m_hold == 0) ? 4'b0001 : 4'b0000);
            applyStimulus(r, 32'h8877_6655, "prio_pulse");
        end
        repeat (16) applyStimulus(4'b1110, 32'h8877_6655, "prio_released");

        for (int i = 0; i < 300; i++) begin
            r = N_REQ'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            d = $urandom;
            if (i == 150) doAsyncReset("random_reset");
            applyStimulus(r, d, "random");
        end

        @(negedge clk);
        checkOutput("final");
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
